// File: rtl/rs232_frame_decoder.sv
// Decodes byte-stream frames (0xFF, CMD, LEN, LEN data bytes LSB-first) into a
// parallel CMD/LEN/DATA word with valid/error strobes and an inter-byte timeout.
module rs232_frame_decoder #(
    parameter int MAX_LEN        = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    input  logic [7:0]           RX_DATA,
    input  logic                 RX_VALID,
    output logic [7:0]           FRAME_CMD,
    output logic [7:0]           FRAME_LEN,
    output logic [8*MAX_LEN-1:0] FRAME_DATA,
    output logic                 FRAME_VALID,
    output logic                 FRAME_ERR,
    output logic [1:0]           ERR_CODE
);

    localparam int            DW        = 8 * MAX_LEN;
    localparam int            TW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [1:0]    ERR_OVF   = 2'd1;
    localparam logic [1:0]    ERR_TMO   = 2'd2;

    typedef enum logic [1:0] {ST_SYNC, ST_CMD, ST_LEN, ST_DATA} state_t;

    state_t        r_state;
    logic [7:0]    r_cmd;
    logic [7:0]    r_len;
    logic [7:0]    r_idx;
    logic [DW-1:0] r_asm;
    logic [TW-1:0] r_tcnt;
    logic [7:0]    r_frame_cmd;
    logic [7:0]    r_frame_len;
    logic [DW-1:0] r_frame_data;
    logic          r_frame_valid;
    logic          r_frame_err;
    logic [1:0]    r_err_code;

    logic [DW-1:0] w_asm_next;
    logic [7:0]    w_idx_inc;
    logic          w_last;
    logic          w_expired;

    // Assembly register with the incoming byte merged into lane r_idx.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_lane
            assign w_asm_next[8*gi +: 8] = (r_idx == 8'(gi)) ? RX_DATA : r_asm[8*gi +: 8];
        end
    endgenerate

    assign w_idx_inc = r_idx + 8'd1;
    assign w_last    = (w_idx_inc == r_len);
    assign w_expired = (r_state != ST_SYNC) && (r_tcnt == TLAST);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state       <= ST_SYNC;
            r_cmd         <= '0;
            r_len         <= '0;
            r_idx         <= '0;
            r_asm         <= '0;
            r_tcnt        <= '0;
            r_frame_cmd   <= '0;
            r_frame_len   <= '0;
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_err_code    <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            if (r_state == ST_SYNC || RX_VALID) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            // A byte on the expiry cycle takes priority over the timeout.
            if (RX_VALID) begin
                case (r_state)
                    ST_SYNC: begin
                        if (RX_DATA == 8'hFF) begin
                            r_state <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        r_cmd   <= RX_DATA;
                        r_state <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (RX_DATA > MAX_LEN_B) begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= ERR_OVF;
                            r_state     <= ST_SYNC;
                        end else if (RX_DATA == 8'd0) begin
                            r_frame_cmd   <= r_cmd;
                            r_frame_len   <= 8'd0;
                            r_frame_data  <= '0;
                            r_frame_valid <= 1'b1;
                            r_state       <= ST_SYNC;
                        end else begin
                            r_len   <= RX_DATA;
                            r_asm   <= '0;
                            r_idx   <= 8'd0;
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        r_asm <= w_asm_next;
                        r_idx <= w_idx_inc;
                        if (w_last) begin
                            r_frame_cmd   <= r_cmd;
                            r_frame_len   <= r_len;
                            r_frame_data  <= w_asm_next;
                            r_frame_valid <= 1'b1;
                            r_state       <= ST_SYNC;
                        end
                    end
                    default: r_state <= ST_SYNC;
                endcase
            end else if (w_expired) begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_TMO;
                r_tcnt      <= '0;
                r_state     <= ST_SYNC;
            end
        end
    end

    assign FRAME_CMD   = r_frame_cmd;
    assign FRAME_LEN   = r_frame_len;
    assign FRAME_DATA  = r_frame_data;
    assign FRAME_VALID = r_frame_valid;
    assign FRAME_ERR   = r_frame_err;
    assign ERR_CODE    = r_err_code;

endmodule

// File: tb/tb_rs232_frame_decoder.sv
// Directed plus randomized frames checked against expectations built from the
// frame contents themselves (payload packing, pulse counts, timeout timing).
module tb_rs232_frame_decoder;

    localparam int ML = 4;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    frame_cmd;
    logic [7:0]    frame_len;
    logic [8*ML-1:0] frame_data;
    logic          frame_valid;
    logic          frame_err;
    logic [1:0]    err_code;

    int tests = 0;
    int fails = 0;
    int vcnt  = 0;
    int ecnt  = 0;

    logic [7:0]      exp_cmd;
    logic [7:0]      exp_len;
    logic [8*ML-1:0] exp_data;

    rs232_frame_decoder #(.MAX_LEN(ML), .TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50   (clk),
        .RESET      (rst),
        .RX_DATA    (rx_data),
        .RX_VALID   (rx_valid),
        .FRAME_CMD  (frame_cmd),
        .FRAME_LEN  (frame_len),
        .FRAME_DATA (frame_data),
        .FRAME_VALID(frame_valid),
        .FRAME_ERR  (frame_err),
        .ERR_CODE   (err_code)
    );

    always #5 clk = ~clk;

    // Pulse counter; reads pre-edge values so each one-cycle pulse counts once.
    always @(posedge clk) begin
        if (frame_valid) vcnt++;
        if (frame_err) ecnt++;
        if (frame_valid || frame_err) begin
            tests++;
            assert (!(frame_valid && frame_err)) else begin
                fails++;
                $error("FAIL valid_err_overlap: observed valid=%0b err=%0b expected not both", frame_valid, frame_err);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    function automatic logic [8*ML-1:0] pack_payload(input logic [7:0] len, input logic [8*ML-1:0] pl);
        logic [8*ML-1:0] r;
        r = '0;
        for (int i = 0; i < ML; i++) begin
            if (i < int'(len)) r[8*i +: 8] = pl[8*i +: 8];
        end
        return r;
    endfunction

    task automatic do_frame(input logic [7:0] cmd, input logic [7:0] len, input logic [8*ML-1:0] pl,
                            input int gap, input bit tail, input int e_extra);
        int  v0, e0;
        bit  bad;
        v0  = vcnt;
        e0  = ecnt;
        bad = (int'(len) > ML);
        send_byte(8'hFF); idle(gap);
        send_byte(cmd);   idle(gap);
        send_byte(len);
        if (bad) begin
            chk("ovf_err", frame_err, 1'b1);
            chk("ovf_code", err_code, 2'd1);
            chk("ovf_valid", frame_valid, 1'b0);
            chk("ovf_cmd_hold", frame_cmd, exp_cmd);
            chk("ovf_len_hold", frame_len, exp_len);
            chk("ovf_data_hold", frame_data, exp_data);
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                idle(gap);
                send_byte(pl[8*i +: 8]);
            end
            exp_cmd  = cmd;
            exp_len  = len;
            exp_data = pack_payload(len, pl);
            chk("valid", frame_valid, 1'b1);
            chk("err_quiet", frame_err, 1'b0);
            chk("cmd", frame_cmd, exp_cmd);
            chk("len", frame_len, exp_len);
            chk("data", frame_data, exp_data);
        end
        if (tail) begin
            idle(1);
            chk("pulse_width", frame_valid | frame_err, 1'b0);
            chk("valid_count", vcnt - v0, bad ? 0 : 1);
            chk("err_count", ecnt - e0, (bad ? 1 : 0) + e_extra);
        end
    endtask

    initial begin
        int v0, e0;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        exp_cmd = '0; exp_len = '0; exp_data = '0;
        idle(3);
        chk("rst_cmd", frame_cmd, 8'h00);
        chk("rst_len", frame_len, 8'h00);
        chk("rst_data", frame_data, '0);
        chk("rst_valid", frame_valid, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_code", err_code, 2'd0);
        rst = 1'b0;
        idle(2);

        // Single-byte frame with spacing, then a 3-byte frame and an empty frame.
        do_frame(8'h00, 8'd1, 32'h0000001E, 3, 1, 0);
        do_frame(8'h01, 8'd3, 32'h00021234, 0, 1, 0);
        do_frame(8'h00, 8'd0, 32'hDEADBEEF, 1, 1, 0);

        // Garbage is dropped silently; 0xFF as data is ordinary.
        v0 = vcnt; e0 = ecnt;
        send_byte(8'h12); send_byte(8'hAB); send_byte(8'h00);
        idle(3);
        chk("garbage_valid", vcnt - v0, 0);
        chk("garbage_err", ecnt - e0, 0);
        do_frame(8'h01, 8'd1, 32'h000000FF, 0, 1, 0);

        // Length overflow, then a frame starting on the error cycle.
        do_frame(8'h01, 8'd5, 32'h0, 0, 0, 0);
        do_frame(8'h00, 8'd1, 32'h00000007, 0, 1, 1);

        // Timeout: error appears exactly TO cycles after the last byte, once.
        e0 = ecnt;
        send_byte(8'hFF); send_byte(8'h01); send_byte(8'h03); send_byte(8'h34);
        idle(TO - 1);
        chk("tmo_early", frame_err, 1'b0);
        idle(1);
        chk("tmo_err", frame_err, 1'b1);
        chk("tmo_code", err_code, 2'd2);
        chk("tmo_data_hold", frame_data, exp_data);
        idle(3 * TO);
        chk("tmo_once", ecnt - e0, 1);

        // Bytes landing on the expiry edge win over the timeout.
        e0 = ecnt; v0 = vcnt;
        send_byte(8'hFF); send_byte(8'h01); send_byte(8'h03); send_byte(8'h34);
        idle(TO - 1); send_byte(8'h12);
        idle(TO - 1); send_byte(8'h02);
        exp_cmd = 8'h01; exp_len = 8'd3; exp_data = 32'h00021234;
        chk("edge_valid", frame_valid, 1'b1);
        chk("edge_data", frame_data, exp_data);
        idle(2 * TO);
        chk("edge_no_err", ecnt - e0, 0);
        chk("edge_one_valid", vcnt - v0, 1);

        // Reset mid-frame discards the partial frame.
        send_byte(8'hFF); send_byte(8'h01); send_byte(8'h03); send_byte(8'h34);
        rst = 1'b1; idle(2); rst = 1'b0; idle(1);
        exp_cmd = '0; exp_len = '0; exp_data = '0;
        chk("mid_rst_data", frame_data, exp_data);
        e0 = ecnt; v0 = vcnt;
        send_byte(8'h12); send_byte(8'h02);
        idle(2 * TO);
        chk("post_rst_valid", vcnt - v0, 0);
        chk("post_rst_err", ecnt - e0, 0);
        do_frame(8'h5A, 8'd2, 32'h0000C3A5, 1, 1, 0);

        // Randomized frames, some preceded by garbage, some overflowing.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] c, l;
            logic [31:0] p;
            int g;
            if ($urandom_range(0, 2) == 0) begin
                v0 = vcnt; e0 = ecnt;
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) send_byte(8'($urandom_range(0, 254)));
                idle(2);
                chk("rnd_garbage", (vcnt - v0) + (ecnt - e0), 0);
            end
            c = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) l = 8'($urandom_range(ML + 1, 255));
            else l = 8'($urandom_range(0, ML));
            p = $urandom;
            g = int'($urandom_range(0, 6));
            do_frame(c, l, p, g, 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rs232_frame_decoder.md
Name: rs232_frame_decoder

Overview:
Receive-side counterpart of the board's UART frame sender. It consumes bytes from the UART receiver and decodes frames of the form 0xFF (sync), CMD, LEN, then LEN data bytes sent LSB-first. A complete frame is presented as a parallel CMD/LEN/DATA word with a one-cycle valid strobe. Malformed or stalled frames are reported with an error strobe, and the decoder resynchronises on the next 0xFF.

Parameters:
MAX_LEN, 4, maximum data bytes per frame; the FRAME_DATA width is 8*MAX_LEN.
TIMEOUT_CYCLES, 100000, inter-byte timeout in clocks (2 ms at 50 MHz); minimum 2.

Ports:
CLOCK_50  input  1  system clock; everything runs on its rising edge
RESET  input  1  asynchronous, active-high reset
RX_DATA  input  8  received byte; valid only while RX_VALID=1
RX_VALID  input  1  one-cycle strobe per received byte from the UART receiver
FRAME_CMD  output  8  command byte of the last good frame
FRAME_LEN  output  8  length byte of the last good frame
FRAME_DATA  output  8*MAX_LEN  payload of the last good frame; byte 0 in [7:0]; bytes at index >= LEN are 0
FRAME_VALID  output  1  one-cycle pulse when a good frame completes
FRAME_ERR  output  1  one-cycle pulse when a frame is aborted
ERR_CODE  output  2  reason for the abort, valid with FRAME_ERR: 1 = length overflow, 2 = timeout; holds its value otherwise

Behaviour:
- Reset state: state=ST_SYNC. All outputs, the shift/assembly registers, the byte counter and the timeout counter are 0.
- RESET asserted mid-frame discards the partial frame. No strobe is generated.
- Only rising edges of CLOCK_50 with RX_VALID=1 consume a byte. The block has no backpressure, so every strobe is accepted.
- State machine, one transition per accepted byte:
  - ST_SYNC: byte 0xFF -> ST_CMD. Any other byte is dropped silently.
  - ST_CMD: latch the byte into the internal cmd register -> ST_LEN. 0xFF is a valid command here; there is no escaping.
  - ST_LEN:
    - byte > MAX_LEN: FRAME_ERR=1 and ERR_CODE=1 on the next cycle; go to ST_SYNC.
    - byte = 0: the frame completes; go to ST_SYNC.
    - otherwise: latch len, clear the assembly register, set byte index to 0, go to ST_DATA.
  - ST_DATA: write the byte to assembly bits [8*idx+7 : 8*idx] and increment idx. When idx+1 = len, the frame completes; go to ST_SYNC. 0xFF is ordinary data.
- Frame completion: on the clock edge that accepts the final byte, FRAME_CMD, FRAME_LEN and FRAME_DATA are loaded and FRAME_VALID=1 for exactly that following cycle. Latency is 1 clock from the last RX_VALID to FRAME_VALID.
- FRAME_CMD, FRAME_LEN and FRAME_DATA change only at completion and hold between frames. Error events never modify them.
- Timeout:
  - The counter clears on every accepted byte and while in ST_SYNC. It increments each clock in ST_CMD, ST_LEN and ST_DATA.
  - When it reaches TIMEOUT_CYCLES-1 without a byte: FRAME_ERR=1 and ERR_CODE=2 for one cycle, then go to ST_SYNC with the counter cleared.
- Simultaneous RX_VALID and timeout expiry in the same cycle: the byte wins. It is processed normally, the counter clears, and no error is raised.
- FRAME_VALID and FRAME_ERR are never asserted in the same cycle.
- A byte arriving in the cycle FRAME_VALID or FRAME_ERR is high is processed normally in ST_SYNC, so back-to-back frames with zero gap are supported.

Test Plan:
- Bytes FF 00 01 1E at any spacing -> one FRAME_VALID pulse 1 clk after 0x1E; FRAME_CMD=00, FRAME_LEN=01, FRAME_DATA=0x0000001E.
- Bytes FF 01 03 34 12 02 -> FRAME_CMD=01, FRAME_LEN=03, FRAME_DATA=0x00021234. Then FF 00 00 -> FRAME_VALID with LEN=0, DATA=0, CMD=00.
- Garbage 12 AB 00 followed by FF 01 01 FF -> no strobes during the garbage; one FRAME_VALID with CMD=01, DATA=0x000000FF.
- FF 01 05 (MAX_LEN=4) -> FRAME_ERR with ERR_CODE=1 and outputs unchanged. An immediate FF 00 01 07 -> FRAME_VALID, DATA=0x07.
- FF 01 03 34, then silence for TIMEOUT_CYCLES (run with TIMEOUT_CYCLES=20) -> exactly one FRAME_ERR with ERR_CODE=2. Also deliver a byte exactly on the expiry cycle -> no error, and the frame continues.
- Assert RESET after FF 01 03 34, release it, then send 12 02 -> no strobes. A following full frame decodes correctly.
